// File: rtl/hazard_ctrl.sv
// hazard_ctrl: stall/flush/forward sequencing for the 5-stage core.
// Ports: D/E/M/W register addresses and enables, dmem handshake,
//   err_clr in; stall_F..stall_M, flush_D/E/W, forwardA/B_E,
//   mem_err, stall_cnt, flush_cnt out.
module hazard_ctrl #(
    parameter int unsigned TIMEOUT = 16,
    parameter int unsigned CNT_W   = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [4:0]       rs1_addr_D,
    input  logic [4:0]       rs2_addr_D,
    input  logic [4:0]       rs1_addr_E,
    input  logic [4:0]       rs2_addr_E,
    input  logic [4:0]       rd_addr_E,
    input  logic [4:0]       rd_addr_M,
    input  logic [4:0]       rd_addr_W,
    input  logic             dmem_read_E,
    input  logic             RegWrite_M,
    input  logic             RegWrite_W,
    input  logic             PCSrc_E,
    input  logic             dmem_req_M,
    input  logic             dmem_ready,
    input  logic             err_clr,
    output logic             stall_F,
    output logic             stall_D,
    output logic             stall_E,
    output logic             stall_M,
    output logic             flush_D,
    output logic             flush_E,
    output logic             flush_W,
    output logic [1:0]       forwardA_E,
    output logic [1:0]       forwardB_E,
    output logic             mem_err,
    output logic [CNT_W-1:0] stall_cnt,
    output logic [CNT_W-1:0] flush_cnt
);

    typedef enum logic {
        RUN,
        MEM_WAIT
    } state_t;

    localparam logic [7:0] TIMEOUT_C = 8'(TIMEOUT);
    localparam logic [CNT_W-1:0] CNT_MAX = '1;
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    state_t     state;
    state_t     state_nxt;
    logic [7:0] wait_cnt;
    logic [7:0] wait_cnt_nxt;

    logic memwait;
    logic loaduse;
    logic freeze;
    logic apply;
    logic timeout;

    logic stall_F_raw;
    logic stall_D_raw;
    logic stall_E_raw;
    logic stall_M_raw;
    logic flush_D_raw;
    logic flush_E_raw;
    logic flush_W_raw;

    assign memwait = dmem_req_M & ~dmem_ready;

    assign loaduse = dmem_read_E
                   & (rd_addr_E != 5'd0)
                   & ((rd_addr_E == rs1_addr_D)
                   |  (rd_addr_E == rs2_addr_D));

    // Sequencing: 'apply' means the pipeline is free to move this
    // cycle, so the redirect and load-use rules take effect.
    always_comb begin
        state_nxt    = state;
        wait_cnt_nxt = wait_cnt;
        freeze       = 1'b0;
        apply        = 1'b0;
        timeout      = 1'b0;
        unique case (state)
            RUN: begin
                if (memwait) begin
                    freeze       = 1'b1;
                    wait_cnt_nxt = 8'd1;
                    state_nxt    = MEM_WAIT;
                end else begin
                    apply = 1'b1;
                end
            end
            MEM_WAIT: begin
                if (dmem_ready) begin
                    apply        = 1'b1;
                    wait_cnt_nxt = 8'd0;
                    state_nxt    = RUN;
                end else if (wait_cnt < TIMEOUT_C) begin
                    freeze       = 1'b1;
                    wait_cnt_nxt = wait_cnt + 8'd1;
                end else begin
                    // Abandon the access; the MEM/WB slot is a bubble.
                    timeout      = 1'b1;
                    apply        = 1'b1;
                    wait_cnt_nxt = 8'd0;
                    state_nxt    = RUN;
                end
            end
            default: begin
                wait_cnt_nxt = 8'd0;
                state_nxt    = RUN;
            end
        endcase
    end

    // Control priority: freeze > redirect > load-use.
    always_comb begin
        stall_F_raw = 1'b0;
        stall_D_raw = 1'b0;
        stall_E_raw = 1'b0;
        stall_M_raw = 1'b0;
        flush_D_raw = 1'b0;
        flush_E_raw = 1'b0;
        flush_W_raw = timeout;
        if (freeze) begin
            stall_F_raw = 1'b1;
            stall_D_raw = 1'b1;
            stall_E_raw = 1'b1;
            stall_M_raw = 1'b1;
            flush_W_raw = 1'b1;
        end else if (apply && PCSrc_E) begin
            // Decode instruction is flushed, so load-use is moot.
            flush_D_raw = 1'b1;
            flush_E_raw = 1'b1;
        end else if (apply && loaduse) begin
            stall_F_raw = 1'b1;
            stall_D_raw = 1'b1;
            flush_E_raw = 1'b1;
        end
    end

    assign stall_F = ~reset & stall_F_raw;
    assign stall_D = ~reset & stall_D_raw;
    assign stall_E = ~reset & stall_E_raw;
    assign stall_M = ~reset & stall_M_raw;
    assign flush_D = ~reset & flush_D_raw;
    assign flush_E = ~reset & flush_E_raw;
    assign flush_W = ~reset & flush_W_raw;

    function automatic logic [1:0] fwd_sel(
        input logic [4:0] rs
    );
        logic [1:0] sel;
        sel = 2'b00;
        if (RegWrite_M && rd_addr_M != 5'd0
            && rd_addr_M == rs)
            sel = 2'b10;
        else if (RegWrite_W && rd_addr_W != 5'd0
                 && rd_addr_W == rs)
            sel = 2'b01;
        return sel;
    endfunction

    assign forwardA_E = reset ? 2'b00 : fwd_sel(rs1_addr_E);
    assign forwardB_E = reset ? 2'b00 : fwd_sel(rs2_addr_E);

    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= RUN;
            wait_cnt <= 8'd0;
        end else begin
            state    <= state_nxt;
            wait_cnt <= wait_cnt_nxt;
        end
    end

    // Timeout set beats a same-cycle clear.
    always_ff @(posedge clk) begin
        if (reset)
            mem_err <= 1'b0;
        else if (timeout)
            mem_err <= 1'b1;
        else if (err_clr)
            mem_err <= 1'b0;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            stall_cnt <= '0;
            flush_cnt <= '0;
        end else begin
            if (stall_F && stall_cnt != CNT_MAX)
                stall_cnt <= stall_cnt + CNT_ONE;
            if (flush_E && flush_cnt != CNT_MAX)
                flush_cnt <= flush_cnt + CNT_ONE;
        end
    end

endmodule
